rat_ckpt: RTL
=============

// Module: rat_ckpt
// PURPOSE
//  Register Alias Table with branch checkpoints for the Tomasulo core. Maps each architectural
//  register to its in-flight ROB producer. Holds up to NUM_CKPT snapshots in a FIFO ring, so
//  a mispredicted branch restores the map in one cycle instead of flushing the whole pipeline.
//  Sits between decode/dispatch (rename), the ROB (commit) and the branch unit (restore/release).
// PARAMETERS
//  ROB_ID_W   4  width of ROB tag
//  NUM_CKPT   4  checkpoint slots, power of two, >=2
//  CKPT_ID_W  2  log2(NUM_CKPT)
// PORTS
//  clk            in   1          clock, rising edge
//  rst            in   1          synchronous, active-high reset
//  flush          in   1          full pipeline flush: clear map and all checkpoints
//  we             in   1          rename allocate
//  rw_addr        in   5          destination arch reg
//  write_rob_id   in   ROB_ID_W   ROB tag of new producer
//  rs1_addr       in   5          source 1 arch reg
//  rs1_valid      out  1          1 = source 1 is pending in the ROB
//  rs1_rob_id     out  ROB_ID_W   producer tag of source 1
//  rs2_addr       in   5          source 2 arch reg
//  rs2_valid      out  1          1 = source 2 is pending in the ROB
//  rs2_rob_id     out  ROB_ID_W   producer tag of source 2
//  commit_we      in   1          ROB commits a register write
//  commit_addr    in   5          committed arch reg
//  commit_rob_id  in   ROB_ID_W   committed tag
//  ckpt_req       in   1          take a snapshot (branch dispatch)
//  ckpt_grant     out  1          snapshot taken this cycle
//  ckpt_id        out  CKPT_ID_W  slot id of the snapshot (= tail)
//  ckpt_full      out  1          all slots in use
//  ckpt_release   in   1          oldest branch resolved correct: free head slot
//  restore_valid  in   1          mispredict: restore map from restore_id
//  restore_id     in   CKPT_ID_W  slot to restore
// BEHAVIOUR
//  - Reset: rst is synchronous, active-high; clock is clk. Reset clears all map_valid bits and
//    all snapshot valid bits, and sets head=tail=count=0. After reset: rs*_valid=0,
//    ckpt_full=0, ckpt_grant=0, ckpt_id=0.
//  - Priority: rst > flush > restore_valid > {commit, alloc, ckpt, release}.
//  - Read ports are combinational from the live map, with no same-cycle alloc bypass.
//    Register x0 always reads valid=0, and is never written or committed.
//  - Commit: clear map_valid[a] when the entry is valid and its tag equals commit_rob_id.
//    Apply the same compare-and-clear to every occupied snapshot.
//  - Alloc (we, rw_addr!=0): set valid and write the tag. Alloc overrides a same-cycle commit
//    to the same register.
//  - ckpt_grant = ckpt_req & !ckpt_full & !restore_valid & !flush.
//    * On grant, the snapshot at tail captures the post-update map of this cycle:
//      this cycle's commit clear and this cycle's alloc are both included.
//    * On grant, tail++ (wraps modulo NUM_CKPT) and count++.
//  - ckpt_release: head++ (wraps) and count--. A release while count==0 is ignored.
//  - Release and grant in the same cycle: count is unchanged; both pointers advance.
//  - ckpt_full = (count==NUM_CKPT). A request while full is dropped (grant=0). A release in the
//    same cycle does not create room until the next cycle.
//  - Restore (restore_id must be occupied):
//    * Live map <= snapshot[restore_id], with this cycle's commit clear applied.
//    * The same-cycle alloc and ckpt_req are discarded.
//    * tail <= restore_id, which frees that slot and all younger slots.
//    * count <= restore_id - head (mod NUM_CKPT), minus 1 if release is asserted (head++).
//  - restore_valid with restore_id==head and ckpt_release in the same cycle is illegal
//    (bench assertion).
//  - flush: live map cleared and all slots freed. Other same-cycle inputs are ignored.
//  - rst mid-operation discards all in-flight state, with no partial snapshot.
// TESTING
//  - Reset, then alloc x5->tag3; next cycle rs1_addr=5 -> rs1_valid=1, rs1_rob_id=3.
//    Then commit x5 tag3 -> rs1_valid=0 next cycle.
//  - Alloc x5->3, then alloc x5->7, then commit x5 tag3 -> x5 stays valid, tag 7.
//    Commit and alloc of x6 in the same cycle -> x6 valid with the new tag.
//  - Alloc x1->2 with ckpt_req (grant, id 0); then alloc x1->4, x2->5;
//    restore_id=0 -> x1 valid tag 2, x2 invalid, ckpt_full=0, count 0.
//  - Take 4 checkpoints -> ckpt_full=1; a 5th req gives grant=0.
//    Then release -> full=0 next cycle; the next grant returns id 0 (wrap).
//  - Snapshot holds x3->6; commit x3 tag6; then restore that slot -> x3 invalid
//    (commit cleaned the snapshot).
//  - Alloc/ckpt with flush=1 in the same cycle -> all rs*_valid=0, ckpt_full=0,
//    and the next grant returns id 0.

Source files
------------

// File: rtl/rat_ckpt_if.sv
// Rename / commit / checkpoint bundle for the register alias table.
// The master modport drives requests; the slave modport is the RAT itself.
interface rat_ckpt_if #(
  parameter int ROB_ID_W  = 4,
  parameter int CKPT_ID_W = 2
);
  logic                 flush;
  logic                 we;
  logic [4:0]           rw_addr;
  logic [ROB_ID_W-1:0]  write_rob_id;
  logic [4:0]           rs1_addr;
  logic                 rs1_valid;
  logic [ROB_ID_W-1:0]  rs1_rob_id;
  logic [4:0]           rs2_addr;
  logic                 rs2_valid;
  logic [ROB_ID_W-1:0]  rs2_rob_id;
  logic                 commit_we;
  logic [4:0]           commit_addr;
  logic [ROB_ID_W-1:0]  commit_rob_id;
  logic                 ckpt_req;
  logic                 ckpt_grant;
  logic [CKPT_ID_W-1:0] ckpt_id;
  logic                 ckpt_full;
  logic                 ckpt_release;
  logic                 restore_valid;
  logic [CKPT_ID_W-1:0] restore_id;

  modport master (
    output flush, we, rw_addr, write_rob_id,
    output rs1_addr, rs2_addr,
    output commit_we, commit_addr, commit_rob_id,
    output ckpt_req, ckpt_release,
    output restore_valid, restore_id,
    input  rs1_valid, rs1_rob_id,
    input  rs2_valid, rs2_rob_id,
    input  ckpt_grant, ckpt_id, ckpt_full
  );

  modport slave (
    input  flush, we, rw_addr, write_rob_id,
    input  rs1_addr, rs2_addr,
    input  commit_we, commit_addr, commit_rob_id,
    input  ckpt_req, ckpt_release,
    input  restore_valid, restore_id,
    output rs1_valid, rs1_rob_id,
    output rs2_valid, rs2_rob_id,
    output ckpt_grant, ckpt_id, ckpt_full
  );
endinterface

// File: rtl/rat_ckpt.sv
// Register alias table with a FIFO ring of branch checkpoints.
// A mispredict restores the whole map from one slot in a single cycle.
module rat_ckpt #(
  parameter int ROB_ID_W  = 4,
  parameter int NUM_CKPT  = 4,
  parameter int CKPT_ID_W = 2
) (
  input  logic      clk,
  input  logic      rst,
  rat_ckpt_if.slave bus
);
  localparam int CW = CKPT_ID_W + 1;

  logic [31:0]          r_map_v;
  logic [ROB_ID_W-1:0]  r_map_tag [32];
  logic [31:0]          r_snap_v [NUM_CKPT];
  logic [ROB_ID_W-1:0]  r_snap_tag [NUM_CKPT][32];
  logic [CKPT_ID_W-1:0] r_head;
  logic [CKPT_ID_W-1:0] r_tail;
  logic [CW-1:0]        r_count;

  logic [31:0]          w_map_v;
  logic [ROB_ID_W-1:0]  w_map_tag [32];
  logic [31:0]          w_snap_v [NUM_CKPT];
  logic                 w_full;
  logic                 w_grant;
  logic                 w_rel;
  logic                 w_cmt;
  logic                 w_alloc;
  logic [CKPT_ID_W-1:0] w_rcnt;
  logic [CW-1:0]        w_cnt_nxt;

  assign w_full  = (r_count == CW'(NUM_CKPT));
  assign w_grant = bus.ckpt_req & ~w_full
                 & ~bus.restore_valid & ~bus.flush;
  assign w_rel   = bus.ckpt_release & (r_count != '0);
  assign w_cmt   = bus.commit_we & (bus.commit_addr != 5'd0);
  assign w_alloc = bus.we & (bus.rw_addr != 5'd0);

  assign bus.ckpt_grant = w_grant;
  assign bus.ckpt_id    = r_tail;
  assign bus.ckpt_full  = w_full;

  assign bus.rs1_valid  = (bus.rs1_addr != 5'd0)
                        & r_map_v[bus.rs1_addr];
  assign bus.rs1_rob_id = r_map_tag[bus.rs1_addr];
  assign bus.rs2_valid  = (bus.rs2_addr != 5'd0)
                        & r_map_v[bus.rs2_addr];
  assign bus.rs2_rob_id = r_map_tag[bus.rs2_addr];

  // Live map after this cycle's commit clear, then alloc on top
  always_comb begin
    w_map_v   = r_map_v;
    w_map_tag = r_map_tag;
    if (w_cmt && r_map_v[bus.commit_addr] &&
        r_map_tag[bus.commit_addr] == bus.commit_rob_id)
      w_map_v[bus.commit_addr] = 1'b0;
    if (w_alloc) begin
      w_map_v[bus.rw_addr]   = 1'b1;
      w_map_tag[bus.rw_addr] = bus.write_rob_id;
    end
  end

  // Commits also retire producers captured in older snapshots
  always_comb begin
    for (int k = 0; k < NUM_CKPT; k++) begin
      w_snap_v[k] = r_snap_v[k];
      if (w_cmt && r_snap_v[k][bus.commit_addr] &&
          r_snap_tag[k][bus.commit_addr] == bus.commit_rob_id)
        w_snap_v[k][bus.commit_addr] = 1'b0;
    end
  end

  assign w_rcnt    = bus.restore_id - r_head - CKPT_ID_W'(w_rel);
  assign w_cnt_nxt = r_count + CW'(w_grant) - CW'(w_rel);

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_map_v <= '0;
      for (int k = 0; k < NUM_CKPT; k++)
        r_snap_v[k] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.restore_valid) begin
      r_map_v   <= w_snap_v[bus.restore_id];
      r_map_tag <= r_snap_tag[bus.restore_id];
      r_snap_v  <= w_snap_v;
      r_tail    <= bus.restore_id;
      r_head    <= r_head + CKPT_ID_W'(w_rel);
      r_count   <= {1'b0, w_rcnt};
    end else begin
      r_map_v   <= w_map_v;
      r_map_tag <= w_map_tag;
      r_snap_v  <= w_snap_v;
      if (w_grant) begin
        r_snap_v[r_tail]   <= w_map_v;
        r_snap_tag[r_tail] <= w_map_tag;
        r_tail             <= r_tail + CKPT_ID_W'(1);
      end
      r_head  <= r_head + CKPT_ID_W'(w_rel);
      r_count <= w_cnt_nxt;
    end
  end
endmodule
